// File: rtl/m_seq_s2p.sv
// PRBS7 test-data source with a serial-to-parallel word builder for the QAM chain.
// One synchronized rising edge of gen_bit_req advances the LFSR and shifts its output bit in.
module m_seq_s2p #(
    parameter logic [6:0] SEED = 7'h7F
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        gen_bit_req,
    input  logic [3:0]  parellel_width_cfg,
    output logic        m_seq_out,
    output logic        complete,
    output logic [15:0] parellel_output
);

    logic        s1, s2, d;
    logic        step;
    logic [6:0]  lfsr;
    logic [15:0] shift;
    logic [4:0]  count;
    logic [4:0]  width;
    logic [15:0] shift_nx;
    logic [4:0]  w_act;
    logic [4:0]  count_inc;
    logic        done;

    function automatic logic [15:0] width_mask(input logic [4:0] w);
        logic [16:0] m;
        m = (17'd1 << w) - 17'd1;
        return m[15:0];
    endfunction

    assign step      = s2 & ~d;
    assign m_seq_out = lfsr[6];

    // Width is sampled only at the first bit of a word so mid-word cfg changes are deferred.
    always_comb begin
        shift_nx  = {shift[14:0], lfsr[6]};
        w_act     = (count == 5'd0) ? ({1'b0, parellel_width_cfg} + 5'd1) : width;
        count_inc = count + 5'd1;
        done      = (count_inc == w_act);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1              <= 1'b0;
            s2              <= 1'b0;
            d               <= 1'b0;
            lfsr            <= SEED;
            shift           <= 16'd0;
            count           <= 5'd0;
            width           <= 5'd0;
            parellel_output <= 16'd0;
            complete        <= 1'b0;
        end else begin
            s1       <= gen_bit_req;
            s2       <= s1;
            d        <= s2;
            complete <= 1'b0;
            if (step) begin
                lfsr  <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
                width <= w_act;
                if (done) begin
                    parellel_output <= shift_nx & width_mask(w_act);
                    complete        <= 1'b1;
                    count           <= 5'd0;
                    shift           <= 16'd0;
                end else begin
                    count <= count_inc;
                    shift <= shift_nx;
                end
            end
        end
    end

endmodule

// File: tb/tb_m_seq_s2p.sv
// Randomized bench for m_seq_s2p against a sequence-recurrence and word-accumulator model.
module tb_m_seq_s2p;

    logic        clk;
    logic        rst_n;
    logic        gen_bit_req;
    logic [3:0]  parellel_width_cfg;
    logic        m_seq_out;
    logic        complete;
    logic [15:0] parellel_output;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    bit          seq [127];
    int          idx;
    int          cnt;
    int          cur_w;
    logic [15:0] acc;
    logic [15:0] last_word;
    int          ones;

    m_seq_s2p dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .gen_bit_req        (gen_bit_req),
        .parellel_width_cfg (parellel_width_cfg),
        .m_seq_out          (m_seq_out),
        .complete           (complete),
        .parellel_output    (parellel_output)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        idx       = 0;
        cnt       = 0;
        cur_w     = 0;
        acc       = 16'd0;
        last_word = 16'd0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        gen_bit_req = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    // One request edge; hold is the number of extra cycles the request stays high.
    task automatic do_step(input int hold);
        bit          b;
        bit          expc;
        logic [15:0] expw;
        b = seq[idx];
        chk("mseq_pre", {31'd0, m_seq_out}, {31'd0, b});
        if (b) ones++;
        if (cnt == 0) cur_w = int'(parellel_width_cfg) + 1;
        acc = {acc[14:0], b};
        cnt++;
        expc = (cnt == cur_w);
        expw = last_word;
        if (expc) begin
            expw      = acc;
            last_word = acc;
            acc       = 16'd0;
            cnt       = 0;
        end
        idx = (idx + 1) % 127;

        @(negedge clk);
        gen_bit_req = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("no_early_complete", {31'd0, complete}, 32'd0);
        chk("no_early_step", {31'd0, m_seq_out}, {31'd0, b});
        @(posedge clk);
        #1;
        chk("complete", {31'd0, complete}, {31'd0, expc});
        chk("mseq_post", {31'd0, m_seq_out}, {31'd0, seq[idx]});
        chk("word", {16'd0, parellel_output}, {16'd0, expw});
        repeat (hold) @(posedge clk);
        #1;
        chk("single_pulse", {31'd0, complete}, 32'd0);
        chk("held_one_step", {31'd0, m_seq_out}, {31'd0, seq[idx]});
        @(negedge clk);
        gen_bit_req = 1'b0;
        repeat ($urandom_range(2, 4)) @(posedge clk);
    endtask

    initial begin
        // x[n+7] = x[n] ^ x[n+1] follows from the shift-left / xor-of-top-two-bits recurrence.
        for (int i = 0; i < 7; i++) seq[i] = 1'b1;
        for (int i = 7; i < 127; i++) seq[i] = seq[i-7] ^ seq[i-6];

        rst_n              = 1'b0;
        gen_bit_req        = 1'b0;
        parellel_width_cfg = 4'd15;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mseq", {31'd0, m_seq_out}, 32'd1);
        chk("rst_complete", {31'd0, complete}, 32'd0);
        chk("rst_word", {16'd0, parellel_output}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("idle_mseq", {31'd0, m_seq_out}, 32'd1);
        chk("idle_word", {16'd0, parellel_output}, 32'h0);

        // 16-bit words
        for (int i = 0; i < 16; i++) do_step(1);
        chk("word16_a", {16'd0, parellel_output}, 32'hFE04);
        for (int i = 0; i < 16; i++) do_step(1);
        chk("word16_b", {16'd0, parellel_output}, 32'h1851);

        // 8-bit words
        apply_reset();
        parellel_width_cfg = 4'd7;
        for (int i = 0; i < 8; i++) do_step(1);
        chk("word8_a", {16'd0, parellel_output}, 32'h00FE);
        for (int i = 0; i < 8; i++) do_step(1);
        chk("word8_b", {16'd0, parellel_output}, 32'h0004);

        // Full period with random widths and hold lengths
        apply_reset();
        ones = 0;
        for (int i = 0; i < 127; i++) begin
            if (cnt == 0) parellel_width_cfg = 4'($urandom_range(0, 15));
            do_step($urandom_range(1, 6));
        end
        chk("period_ones", ones, 32'd64);
        chk("period_wrap", {31'd0, m_seq_out}, 32'd1);

        // Long hold yields one step
        do_step(20);

        // 1-bit words
        apply_reset();
        parellel_width_cfg = 4'd0;
        for (int i = 0; i < 20; i++) do_step($urandom_range(1, 3));

        // Asynchronous reset mid-word
        apply_reset();
        parellel_width_cfg = 4'd15;
        for (int i = 0; i < 10; i++) do_step(1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_rst_mseq", {31'd0, m_seq_out}, 32'd1);
        chk("async_rst_complete", {31'd0, complete}, 32'd0);
        chk("async_rst_word", {16'd0, parellel_output}, 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 16; i++) do_step(1);
        chk("after_rst_word", {16'd0, parellel_output}, 32'hFE04);

        // Width change mid-word takes effect on the next word
        apply_reset();
        parellel_width_cfg = 4'd15;
        for (int i = 0; i < 5; i++) do_step(1);
        parellel_width_cfg = 4'd3;
        for (int i = 0; i < 11; i++) do_step(1);
        chk("midcfg_word16", {16'd0, parellel_output}, 32'hFE04);
        for (int i = 0; i < 12; i++) do_step($urandom_range(1, 4));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
